// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma I subsystem: symbol encoding, rotor and
// reflector wiring tables, turnover notches and the sequencer state type.
package enigma_pkg;

  localparam int SW    = 6;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [SW-1:0] SYM_NONE = 6'd0;
  localparam logic [SW-1:0] SYM_A    = 6'd1;
  localparam logic [SW-1:0] SYM_Z    = 6'd26;

  typedef logic [4:0] letter_t;

  localparam letter_t ROT1_FWD [26] = '{
    5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  localparam letter_t ROT1_INV [26] = '{
    5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
    5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
  localparam letter_t ROT2_FWD [26] = '{
    5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
    5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
  localparam letter_t ROT2_INV [26] = '{
    5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
  localparam letter_t ROT3_FWD [26] = '{
    5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  localparam letter_t ROT3_INV [26] = '{
    5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
    5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
  localparam letter_t REFL_B [26] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  // Turnover letters Q, E, V as 0-based positions.
  localparam letter_t NOTCH_I   = 5'd16;
  localparam letter_t NOTCH_II  = 5'd4;
  localparam letter_t NOTCH_III = 5'd21;

  typedef enum logic [2:0] {LOAD, RD, SEND, CAPT, DONE} state_t;

  function automatic letter_t add26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? letter_t'(s - 6'd26) : letter_t'(s);
  endfunction

  function automatic letter_t sub26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + 6'd26 - {1'b0, b};
    return (s >= 6'd26) ? letter_t'(s - 6'd26) : letter_t'(s);
  endfunction

endpackage

// File: rtl/enigma_cipher_core.sv
// Three-rotor Enigma I core: steps on each valid symbol (with double-step),
// enciphers with the post-step positions and registers the result.
module enigma_cipher_core
  import enigma_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [SW-1:0] in_symb_i,
  output logic [SW-1:0] out_symb_o
);

  letter_t pos_l, pos_m, pos_r;
  letter_t nxt_l, nxt_m, nxt_r;
  letter_t c0, c1, c2, c3, c4, c5, c6, c7;
  logic    valid;
  logic    mid_notch;

  always_comb begin
    valid     = (in_symb_i >= SYM_A) && (in_symb_i <= SYM_Z);
    mid_notch = (pos_m == NOTCH_II);
    nxt_r     = add26(pos_r, 5'd1);
    // Middle rotor at its notch drags itself and the left rotor along.
    nxt_m     = (mid_notch || (pos_r == NOTCH_III)) ? add26(pos_m, 5'd1) : pos_m;
    nxt_l     = mid_notch ? add26(pos_l, 5'd1) : pos_l;

    c0 = valid ? letter_t'(in_symb_i - SYM_A) : '0;
    c1 = sub26(ROT3_FWD[add26(c0, nxt_r)], nxt_r);
    c2 = sub26(ROT2_FWD[add26(c1, nxt_m)], nxt_m);
    c3 = sub26(ROT1_FWD[add26(c2, nxt_l)], nxt_l);
    c4 = REFL_B[c3];
    c5 = sub26(ROT1_INV[add26(c4, nxt_l)], nxt_l);
    c6 = sub26(ROT2_INV[add26(c5, nxt_m)], nxt_m);
    c7 = sub26(ROT3_INV[add26(c6, nxt_r)], nxt_r);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_l      <= '0;
      pos_m      <= '0;
      pos_r      <= '0;
      out_symb_o <= SYM_NONE;
    end else if (valid) begin
      pos_l      <= nxt_l;
      pos_m      <= nxt_m;
      pos_r      <= nxt_r;
      out_symb_o <= {1'b0, c7} + SYM_A;
    end else begin
      out_symb_o <= SYM_NONE;
    end
  end

endmodule

// File: rtl/enigma_system.sv
// Enigma subsystem top: plaintext RAM, ciphertext RAM and the sequencer that
// streams symbols 0..N-1 through the cipher core, three cycles per symbol.
module enigma_system
  import enigma_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] symb_numb,
  input  logic          dr_we_i,
  input  logic [SW-1:0] dr_data_i,
  input  logic [AW-1:0] dr_addr_i,
  output logic [SW-1:0] dr_data_o,
  output logic [SW-1:0] fr_data_o
);

  logic [SW-1:0] dmem [DEPTH];
  logic [SW-1:0] fmem [DEPTH];

  state_t        state, state_nxt;
  logic [AW-1:0] wr_cnt, idx;
  logic [SW-1:0] cur_symb, core_in, core_out;
  logic          load_wr, fetch, capt_wr, last_load, last_capt;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_in   = SYM_NONE;
    load_wr   = 1'b0;
    fetch     = 1'b0;
    capt_wr   = 1'b0;
    // 5-bit compares so symb_numb=0 can never match a count.
    last_load = ({1'b0, wr_cnt} + 5'd1) == {1'b0, symb_numb};
    last_capt = ({1'b0, idx} + 5'd1) == {1'b0, symb_numb};
    case (state)
      LOAD: begin
        if (dr_we_i) begin
          load_wr = 1'b1;
          if (last_load) state_nxt = RD;
        end
      end
      RD: begin
        fetch     = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        core_in   = cur_symb;
        state_nxt = CAPT;
      end
      CAPT: begin
        capt_wr   = 1'b1;
        state_nxt = last_capt ? DONE : RD;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        dmem[i] <= '0;
        fmem[i] <= '0;
      end
      dr_data_o <= '0;
      fr_data_o <= '0;
      wr_cnt    <= '0;
      idx       <= '0;
      cur_symb  <= '0;
    end else begin
      dr_data_o <= dmem[dr_addr_i];
      fr_data_o <= fmem[dr_addr_i];
      if (load_wr) begin
        dmem[dr_addr_i] <= dr_data_i;
        wr_cnt          <= wr_cnt + 4'd1;
        if (last_load) idx <= '0;
      end
      if (fetch) cur_symb <= dmem[idx];
      if (capt_wr) begin
        fmem[idx] <= core_out;
        idx       <= idx + 4'd1;
      end
    end
  end

  enigma_cipher_core u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_symb_i  (core_in),
    .out_symb_o (core_out)
  );

endmodule

// File: tb/tb_enigma_system.sv
// Bench for enigma_system: directed and random loads, then read-back of both
// RAMs against a string-table Enigma model via an expected-value queue.
module tb_enigma_system;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] symb_numb = 4'd0;
  logic       dr_we_i = 1'b0;
  logic [5:0] dr_data_i = 6'd0;
  logic [3:0] dr_addr_i = 4'd0;
  logic [5:0] dr_data_o, fr_data_o;

  enigma_system dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .symb_numb (symb_numb),
    .dr_we_i   (dr_we_i),
    .dr_data_i (dr_data_i),
    .dr_addr_i (dr_addr_i),
    .dr_data_o (dr_data_o),
    .fr_data_o (fr_data_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Entry: {addr[3:0], dr[5:0], fr[5:0]}
  logic [15:0] exp_q[$];
  logic        rd_req = 1'b0;
  logic        rd_req_d = 1'b0;

  // Reference model state
  int dmem_m[16];
  int fmem_m[16];
  int n_m = 0;
  int cnt_m = 0;
  bit started_m = 0;

  string rot_w[3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ",
                      "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                      "BDFHJLCPRTXVZNYEIWGAKMUSQO"};
  string refl_w = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int    notch[3] = '{16, 4, 21};

  function automatic int fwd(int r, int i);
    return int'(rot_w[r][i]) - 65;
  endfunction

  function automatic int inv(int r, int o);
    for (int i = 0; i < 26; i++) if (fwd(r, i) == o) return i;
    return 0;
  endfunction

  function automatic int refl(int i);
    return int'(refl_w[i]) - 65;
  endfunction

  // pos[0]=left, pos[1]=middle, pos[2]=right
  task automatic model_encode();
    int pos[3];
    int s, x;
    bit mid_at, right_at;
    pos = '{0, 0, 0};
    for (int k = 0; k < n_m; k++) begin
      s = dmem_m[k];
      if (s < 1 || s > 26) begin
        fmem_m[k] = 0;
      end else begin
        mid_at   = (pos[1] == notch[1]);
        right_at = (pos[2] == notch[2]);
        pos[2] = (pos[2] + 1) % 26;
        if (right_at || mid_at) pos[1] = (pos[1] + 1) % 26;
        if (mid_at) pos[0] = (pos[0] + 1) % 26;
        x = s - 1;
        for (int r = 2; r >= 0; r--) x = (fwd(r, (x + pos[r]) % 26) - pos[r] + 26) % 26;
        x = refl(x);
        for (int r = 0; r <= 2; r++) x = (inv(r, (x + pos[r]) % 26) - pos[r] + 26) % 26;
        fmem_m[k] = x + 1;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      dmem_m[i] = 0;
      fmem_m[i] = 0;
    end
    cnt_m = 0;
    started_m = 0;
  endtask

  // Monitor: a read issued before a rising edge shows up after it.
  always @(posedge clk_i) rd_req_d <= rd_req;

  always @(negedge clk_i) begin
    logic [15:0] e;
    if (rd_req_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: dr=%0d fr=%0d with no expected entry", dr_data_o, fr_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({dr_data_o, fr_data_o} !== e[11:0]) begin
          errors++;
          $display("FAIL rd_addr%0d: got dr=%0d fr=%0d, expected dr=%0d fr=%0d",
                   e[15:12], dr_data_o, fr_data_o, e[11:6], e[5:0]);
        end
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic do_reset();
    rst_i = 1'b1;
    dr_we_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
  endtask

  task automatic set_n(input int n);
    symb_numb = 4'(n);
    n_m = n;
  endtask

  task automatic write_sym(input int a, input int s);
    dr_we_i   = 1'b1;
    dr_addr_i = 4'(a);
    dr_data_i = 6'(s);
    if (!started_m) begin
      dmem_m[a] = s;
      cnt_m++;
      if (n_m != 0 && cnt_m == n_m) begin
        started_m = 1;
        model_encode();
      end
    end
    @(negedge clk_i);
    dr_we_i = 1'b0;
  endtask

  task automatic issue_read(input int a, input int d, input int f);
    logic [3:0] a4;
    logic [5:0] d6, f6;
    a4 = 4'(a);
    d6 = 6'(d);
    f6 = 6'(f);
    dr_addr_i = a4;
    rd_req = 1'b1;
    exp_q.push_back({a4, d6, f6});
    @(negedge clk_i);
    rd_req = 1'b0;
  endtask

  task automatic read_model(input int a);
    issue_read(a, dmem_m[a], fmem_m[a]);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) read_model(a);
  endtask

  int bdzgo[5] = '{2, 4, 26, 7, 15};
  int enigma_w[6] = '{5, 14, 9, 7, 13, 1};
  int zero_p[3] = '{1, 0, 1};
  int zero_c[3] = '{2, 0, 4};

  initial begin
    int n, s, r, extra;
    @(negedge clk_i);
    do_reset();
    read_all();

    // Known AAAAA -> BDZGO
    set_n(5);
    for (int i = 0; i < 5; i++) write_sym(i, 1);
    repeat (16) @(negedge clk_i);
    for (int i = 0; i < 5; i++) issue_read(i, 1, bdzgo[i]);

    // Reciprocity: BDZGO -> AAAAA
    do_reset();
    set_n(5);
    for (int i = 0; i < 5; i++) write_sym(i, bdzgo[i]);
    repeat (16) @(negedge clk_i);
    for (int i = 0; i < 5; i++) issue_read(i, bdzgo[i], 1);

    // Writes after the load completes are ignored
    do_reset();
    set_n(6);
    for (int i = 0; i < 6; i++) write_sym(i, enigma_w[i]);
    write_sym(6, 17);
    write_sym(7, 23);
    write_sym(8, 5);
    repeat (20) @(negedge clk_i);
    for (int i = 6; i < 9; i++) issue_read(i, 0, 0);
    read_all();

    // Zero symbol passes through without stepping
    do_reset();
    set_n(3);
    for (int i = 0; i < 3; i++) write_sym(i, zero_p[i]);
    repeat (12) @(negedge clk_i);
    for (int i = 0; i < 3; i++) issue_read(i, zero_p[i], zero_c[i]);

    // Reset while the first symbol is in SEND
    do_reset();
    set_n(5);
    for (int i = 0; i < 5; i++) write_sym(i, 1);
    @(negedge clk_i);
    do_reset();
    read_all();
    set_n(5);
    for (int i = 0; i < 5; i++) write_sym(i, 1);
    repeat (16) @(negedge clk_i);
    for (int i = 0; i < 5; i++) issue_read(i, 1, bdzgo[i]);

    // symb_numb=0 never starts: plaintext lands, final RAM stays empty
    do_reset();
    set_n(0);
    for (int i = 0; i < 4; i++) write_sym(i, i + 3);
    repeat (8) @(negedge clk_i);
    read_all();

    // Randomized loads
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = (it == 0) ? 15 : int'($urandom_range(1, 15));
      set_n(n);
      for (int i = 0; i < n; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 5)       s = int'($urandom_range(27, 63));
        else if (r < 12) s = 0;
        else             s = int'($urandom_range(1, 26));
        write_sym(i, s);
      end
      extra = int'($urandom_range(0, 3));
      for (int i = 0; i < extra; i++)
        write_sym(int'($urandom_range(0, 15)), int'($urandom_range(1, 26)));
      repeat (3 * n + 4) @(negedge clk_i);
      read_all();
    end

    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected reads never observed, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enigma_system.md
Name: enigma_system

Overview:
- Self-contained Enigma I cipher subsystem.
- Combines the wrapper controller (plaintext RAM, final RAM, sequencer) with the rotor cipher core.
- Host loads plaintext symbols into a 16-entry default RAM. After symb_numb writes, the wrapper streams symbols 0..N-1 through the core and stores ciphertext in a 16-entry final RAM.
- Both RAMs are readable through a shared address port.

Parameters:
- DEPTH, 16: entries per RAM (address width 4).
- SW, 6: symbol width. Encoding: 1..26 = A..Z; 0 = no symbol.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- symb_numb  in  4  number of symbols to load and encode; must stay stable while loading.
- dr_we_i  in  1  default-RAM write enable.
- dr_data_i  in  6  plaintext symbol to write.
- dr_addr_i  in  4  shared address: write address for the default RAM; read address for both RAMs.
- dr_data_o  out  6  registered default-RAM read data.
- fr_data_o  out  6  registered final-RAM read data.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - both RAM arrays, dr_data_o, fr_data_o, counters and core out register cleared to 0;
  - rotors set to A,A,A; FSM to LOAD.
  - Reset mid-encode aborts the encode.
- Reads: dr_data_o <= dmem[dr_addr_i] and fr_data_o <= fmem[dr_addr_i] every cycle.
  - 1-cycle latency.
  - A read of the address being written returns the old data.
  - X on the address is tolerated; data out is don't-care.
- FSM states: LOAD, RD, SEND, CAPT, DONE.
- LOAD:
  - If dr_we_i=1: dmem[dr_addr_i] <= dr_data_i and wr_cnt++.
  - On the write where wr_cnt+1 == symb_numb: go to RD with idx=0.
  - symb_numb=0 never starts an encode.
  - Writes outside LOAD are ignored; RAM and counter are unchanged.
- Per symbol, 3 cycles:
  - RD: fetch dmem[idx].
  - SEND: drive core input with that symbol for exactly one cycle.
  - CAPT: fmem[idx] <= core output, then idx++.
  - After the CAPT for idx == symb_numb-1, go to DONE; otherwise go to RD.
  - Core input is 0 in all other states.
- DONE: hold until reset. The final RAM stays readable.
- Encode time: 3*symb_numb cycles after the triggering write.
- Core input rules:
  - Valid symbol 1..26: stepping happens on the clock edge, then the symbol is enciphered with the post-step positions.
  - Result is registered into out_symb_o (1-cycle latency).
  - Input 0 or 27..63: no step; out_symb_o <= 0.
- Rotor order, left to right: I, II, III. Reflector B. Ring settings A.
  - I = EKMFLGDQVZNTOWYHXUSPAIBRCJ, turnover at Q.
  - II = AJDKSIRUXBLHWTMCQGZNPYFVOE, turnover at E.
  - III = BDFHJLCPRTXVZNYEIWGAKMUSQO, turnover at V.
  - Reflector B = YRUHQSLDPXNGOKMIEBFZCWVJAT.
- Stepping, with double-step:
  - Right rotor always steps.
  - If the right rotor is at its notch, the middle rotor steps.
  - If the middle rotor is at its notch, the middle and left rotors both step.
  - Positions wrap Z->A (mod 26).
- Signal path: right -> middle -> left forward, reflector, then left -> middle -> right inverse. Each rotor uses (wiring[(x+pos) mod 26] - pos) mod 26.
- Properties: the cipher is reciprocal, and a letter never maps to itself.

Decomposition:
- enigma_pkg holds:
  - SW, DEPTH;
  - symbol constants (SYM_NONE=0, SYM_A=1, SYM_Z=26);
  - rotor I/II/III forward and inverse tables and reflector B as 26-entry constant arrays;
  - notch positions;
  - the FSM state enum.
- One sub-module, enigma_cipher_core, owns the rotor registers, stepping and mapping. Its ports are clk_i, rst_i, in_symb_i[5:0] and out_symb_o[5:0].
- Top level holds the RAMs, counters and FSM.

Test Plan:
- Reset: assert rst_i 2 cycles -> dr_data_o=0, fr_data_o=0; reading any address returns 0.
- Encode test:
  - symb_numb=5; write 1 (A) to addresses 0..4; wait 16 cycles.
  - Read fr addresses 0..4 -> 2,4,26,7,15 (BDZGO).
  - Read dr addresses 0..4 -> 1.
- Reciprocity: after reset, load 2,4,26,7,15 with symb_numb=5 -> final RAM reads 1,1,1,1,1.
- Extra writes ignored:
  - symb_numb=6; write E,N,I,G,M,A (5,14,9,7,13,1) to addresses 0..5, then 17,23,5 to addresses 6..8.
  - dr addresses 6..8 -> 0.
  - fr addresses 0..5 -> nonzero, each different from the plaintext at the same address.
- Zero symbol: a plaintext entry of 0 -> fr entry 0, and rotors do not step. Check: plaintext 1,0,1 encodes to 2,0,4.
- Reset mid-encode: assert rst_i during SEND -> RAMs cleared, FSM in LOAD, rotors at AAA. A subsequent AAAAA load gives BDZGO again.
